uart_host_arb: RTL

Arbiter and access sequencer that shares the single register port of the `uart_host` core between NREQ requesters, for example the 65C02 bus bridge and the ICD/SPI debug engine. Each requester posts one register access at a time: CTRL, STAT or DATA, read or write. The block grants requesters round-robin, drives a one-cycle strobe onto the `uart_host` register interface, captures the registered read data and returns it with a per-requester acknowledge. A lock input lets one requester keep the port for atomic sequences, such as a STAT poll followed by a DATA read.

---
 rtl/uart_host_arb_pkg.sv | 15 +
 rtl/uart_host_arb_rr_arbiter.sv | 27 ++
 rtl/uart_host_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_host_arb_pkg.sv
// uart_host_arb_pkg: register select, FSM state and STAT bit encodings shared by the uart_host arbiter
package uart_host_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;
  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_STAT = 2'd1;
  localparam logic [1:0] SEL_DATA = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_RX_EMPTY = 7;
  localparam logic [7:0] RDATA_RSVD = 8'hFF;
endpackage

// File: rtl/uart_host_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last granted index, or the held owner
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  input  logic                 i_hold,
  input  logic [N-1:0]         i_owner,
  output logic [N-1:0]         o_pick
);
  localparam int W = $clog2(N);
  logic         w_found;
  logic [W-1:0] w_idx;
  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = W'((int'(i_last) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
    if (i_hold) o_pick = i_owner & i_req;
  end
endmodule

// File: rtl/uart_host_arb.sv
// uart_host_arb: shares the uart_host register port between NREQ requesters with
// round-robin grants, optional lock, one strobe cycle per access and registered read data.
module uart_host_arb
  import uart_host_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   lock_i,
  input  logic [NREQ-1:0]   wr_i,
  input  logic [2*NREQ-1:0] sel_i,
  input  logic [8*NREQ-1:0] wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [7:0]        rdata_o,
  input  logic [7:0]        uart_reg_d_i,
  output logic [7:0]        uart_reg_d_o,
  output logic              uart_reg_wr_o,
  output logic              uart_reg_rd_o,
  output logic              uart_cs_ctrl_o,
  output logic              uart_cs_stat_o,
  output logic              uart_cs_data_o
);
  localparam int W = $clog2(NREQ);
  state_t          r_state, w_next;
  logic [NREQ-1:0] r_gnt, r_ack, w_pick;
  logic [W-1:0]    r_last, w_idx;
  logic [1:0]      r_sel, w_sel;
  logic [7:0]      r_rdata, r_d, w_wdata;
  logic [2:0]      r_cs;
  logic            r_lock, r_wr, r_wr_o, r_rd_o, w_wr, w_hold, w_own_lock;
  // A locked owner keeps the port while it still requests or keeps lock high
  assign w_hold     = r_lock && |((req_i | lock_i) & r_gnt);
  assign w_own_lock = |(lock_i & r_gnt);
  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req   (req_i),
    .i_last  (r_last),
    .i_hold  (w_hold),
    .i_owner (r_gnt),
    .o_pick  (w_pick)
  );
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) w_idx = w_pick[k] ? W'(k) : w_idx;
  end
  assign w_wr    = wr_i[w_idx];
  assign w_sel   = sel_i[{w_idx, 1'b0} +: 2];
  assign w_wdata = wdata_i[{w_idx, 3'b000} +: 8];
  always_comb begin
    w_next = (r_state == ST_IDLE)   ? (|w_pick ? ST_STROBE : ST_IDLE) :
             (r_state == ST_STROBE) ? ST_CAPTURE : ST_IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end
  // Strobe outputs are loaded on the grant edge so they are high for exactly the STROBE cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gnt   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_last  <= W'(NREQ - 1);
      r_lock  <= 1'b0;
      r_wr    <= 1'b0;
      r_sel   <= SEL_CTRL;
      r_d     <= '0;
      r_cs    <= '0;
      r_wr_o  <= 1'b0;
      r_rd_o  <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_d    <= '0;
      r_cs   <= '0;
      r_wr_o <= 1'b0;
      r_rd_o <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (!w_hold) begin
          r_lock <= 1'b0;
          r_gnt  <= w_pick;
        end
        if (|w_pick) begin
          r_last <= w_idx;
          r_wr   <= w_wr;
          r_sel  <= w_sel;
          r_d    <= w_wdata;
          if (w_sel != SEL_RSVD) begin
            r_wr_o <= w_wr;
            r_rd_o <= !w_wr;
            r_cs   <= {w_sel == SEL_DATA, w_sel == SEL_STAT, w_sel == SEL_CTRL};
          end
        end
      end
      if (r_state == ST_CAPTURE) begin
        r_ack   <= r_gnt;
        r_rdata <= (r_sel == SEL_RSVD) ? RDATA_RSVD : r_wr ? 8'h00 : uart_reg_d_i;
        r_lock  <= w_own_lock;
        if (!w_own_lock) r_gnt <= '0;
      end
    end
  end
  assign gnt_o          = r_gnt;
  assign ack_o          = r_ack;
  assign rdata_o        = r_rdata;
  assign uart_reg_d_o   = r_d;
  assign uart_reg_wr_o  = r_wr_o;
  assign uart_reg_rd_o  = r_rd_o;
  assign uart_cs_ctrl_o = r_cs[0];
  assign uart_cs_stat_o = r_cs[1];
  assign uart_cs_data_o = r_cs[2];
endmodule
